wb_trd_unit: RTL and testbench
==============================

Name: wb_trd_unit

Overview:
Parametrised write-back stage for the multithreaded pipeline; successor to the single-thread write-back.
- Selects and aligns load data (byte/half/word, sign/zero extend).
- Gates register-file writes per thread.
- Owns the authoritative per-thread state table (FREE/RUN/SLEEP), driven by sleep/wake/kill commands retiring in WB and by an external wake port.
- Fetch reads the table through run_mask.

Parameters:
NUM_THREAD, 8, number of hardware threads (power of 2, >=2)
TID_W, $clog2(NUM_THREAD), thread-id width (derived)
DATA_W, 32, datapath width (fixed at 32 for alignment logic)
REG_W, 5, register index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid_wb  in  1  WB holds a retiring instruction
flushWB  in  1  squash the WB instruction
tid_wb  in  TID_W  issuing thread
exe_data_wb  in  DATA_W  ALU result
d_rd_data  in  DATA_W  raw data-memory word
wb_sel_wb  in  1  1 = load data, 0 = ALU data
ld_size_wb  in  2  00 byte, 01 half, 10 word
ld_sign_wb  in  1  1 = sign-extend
addr_lo_wb  in  2  load address bits [1:0]
wr_en_wb  in  1  register write request
rd_wb  in  REG_W  destination register
trd_ctrl_wb  in  2  00 none, 01 sleep, 10 wake, 11 kill
target_tid_wb  in  TID_W  wake target
ext_wake_vld  in  1  external wake request
ext_wake_tid  in  TID_W  external wake target
wb_data_wb  out  DATA_W  write-back data
wr_en_final  out  1  qualified register write
wr_tid  out  TID_W  register-file bank select
wr_rd  out  REG_W  register-file index
sleep  out  1  sleep retired this cycle
wake  out  1  wake retired this cycle
kill  out  1  kill retired this cycle
trd_state  out  2*NUM_THREAD  per-thread state, thread i at [2i+1:2i]
run_mask  out  NUM_THREAD  bit i = thread i in RUN
all_done  out  1  every thread FREE

Behaviour:
- Qualifier: act = valid_wb & !flushWB.
- Write path is combinational with zero latency.
  - wr_en_final = wr_en_wb & act.
  - wr_tid = tid_wb; wr_rd = rd_wb.
  - sleep/wake/kill are decoded from trd_ctrl_wb and each ANDed with act.
- Load alignment applies when wb_sel_wb = 1.
  - Byte: lane = addr_lo_wb.
  - Half: lane = addr_lo_wb[1]; addr_lo_wb[0] is ignored.
  - Word: addr_lo ignored, passed through.
  - ld_size 11 behaves as word.
  - Byte/half are extended with the lane MSB if ld_sign_wb, else with zeros.
- When wb_sel_wb = 0, wb_data_wb = exe_data_wb.
- State table: one 2-bit state per thread (FREE=00, RUN=01, SLEEP=10) plus one wake_pending bit per thread.
- Reset (async, rst_n low): thread 0 = RUN, all others FREE, all pending bits 0.
  - Outputs after reset: run_mask = 1, all_done = 0.
- All table updates occur on the clk rising edge following an act cycle:
  - Sleep, applies to tid_wb:
    - RUN with pending=1: stays RUN, pending cleared.
    - RUN with pending=0: goes to SLEEP.
    - Any other state: no effect.
  - Wake, applies to target_tid_wb:
    - FREE: goes to RUN (spawn).
    - SLEEP: goes to RUN.
    - RUN: pending set to 1.
  - Kill, applies to tid_wb: goes to FREE, pending cleared.
- External wake uses the same rules as a pipeline wake, applied to ext_wake_tid.
- Simultaneous pipeline command and ext wake on the same thread: the pipeline command is evaluated first, then the ext wake on the result.
  - Sleep + ext wake: the thread ends RUN with pending 0.
  - Kill + ext wake: the thread ends RUN (respawn).
  - Wake + ext wake: one wake (pending set if the thread was already RUN).
- Different target threads update independently in the same cycle.
- flushWB or !valid_wb suppresses every table update and every pulse; ext wake is still honoured.
- Outputs trd_state, run_mask and all_done are decoded from registers only.
  - all_done = no thread in RUN or SLEEP.
- Reset asserted mid-operation returns the table to the reset state immediately, regardless of clock.

Decomposition:
- Package trd_pkg:
  - trd_state_t enum (FREE/RUN/SLEEP).
  - Trd_ctrl codes TRD_NONE/SLEEP/WAKE/KILL.
  - Load size codes LD_B/LD_H/LD_W.
- Sub-module wb_ld_align: purely combinational load alignment and extension.
- Table FSM and write qualification stay in wb_trd_unit.

Test Plan:
1. Reset -> trd_state = 16'h0001, run_mask = 8'h01, all_done = 0, wr_en_final = 0.
2. Load alignment, d_rd_data = 32'h80F0_7F85:
   - Byte, lane 0, signed -> 32'hFFFF_FF85.
   - Byte, lane 3, unsigned -> 32'h0000_0080.
   - Half, addr_lo 2'b10, signed -> 32'hFFFF_80F0.
   - Word -> 32'h80F0_7F85.
3. Thread 0 wakes tid 3 -> next cycle run_mask = 8'h09, wake pulse 1 cycle. Tid 3 then sleeps -> run_mask = 8'h01.
4. Wake-pending race: wake tid 3 while it is RUN, then tid 3 sleeps -> tid 3 stays RUN with pending 0. A second sleep -> SLEEP.
5. Sleep from tid 2 with flushWB = 1 and wr_en_wb = 1 -> wr_en_final = 0, sleep = 0, table unchanged. Ext wake of tid 5 in the same cycle -> tid 5 RUN.
6. Only thread 0 RUN, thread 0 kills -> next cycle run_mask = 0, all_done = 1. Kill on tid 1 plus ext wake of tid 1 in the same cycle -> tid 1 RUN.

Source files
------------

// File: rtl/trd_pkg.sv
// Shared types and encodings for the multithreaded write-back stage:
// thread states, thread-control command codes and load size codes.
package trd_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'b00,
        RUN   = 2'b01,
        SLEEP = 2'b10
    } trd_state_t;

    localparam logic [1:0] TRD_NONE  = 2'b00;
    localparam logic [1:0] TRD_SLEEP = 2'b01;
    localparam logic [1:0] TRD_WAKE  = 2'b10;
    localparam logic [1:0] TRD_KILL  = 2'b11;

    localparam logic [1:0] LD_B = 2'b00;
    localparam logic [1:0] LD_H = 2'b01;
    localparam logic [1:0] LD_W = 2'b10;

endpackage

// File: rtl/wb_ld_align.sv
// Combinational load-data alignment: picks the byte/half lane from the raw
// memory word and sign- or zero-extends it to 32 bits.
module wb_ld_align
    import trd_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = raw_i[7:0];
        half_v = raw_i[15:0];
        data_o = raw_i;

        case (addr_lo_i)
            2'b00:   byte_v = raw_i[7:0];
            2'b01:   byte_v = raw_i[15:8];
            2'b10:   byte_v = raw_i[23:16];
            default: byte_v = raw_i[31:24];
        endcase

        // Half-word lane comes from bit 1 only; bit 0 is ignored.
        half_v = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];

        case (size_i)
            LD_B:    data_o = {{24{sign_i & byte_v[7]}}, byte_v};
            LD_H:    data_o = {{16{sign_i & half_v[15]}}, half_v};
            LD_W:    data_o = raw_i;
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/wb_trd_unit.sv
// Multithreaded write-back: load alignment, register-write qualification and
// the authoritative per-thread FREE/RUN/SLEEP table with wake-pending bits.
module wb_trd_unit
    import trd_pkg::*;
#(
    parameter int NUM_THREAD = 8,
    parameter int TID_W      = $clog2(NUM_THREAD),
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_wb,
    input  logic                    flushWB,
    input  logic [TID_W-1:0]        tid_wb,
    input  logic [DATA_W-1:0]       exe_data_wb,
    input  logic [DATA_W-1:0]       d_rd_data,
    input  logic                    wb_sel_wb,
    input  logic [1:0]              ld_size_wb,
    input  logic                    ld_sign_wb,
    input  logic [1:0]              addr_lo_wb,
    input  logic                    wr_en_wb,
    input  logic [REG_W-1:0]        rd_wb,
    input  logic [1:0]              trd_ctrl_wb,
    input  logic [TID_W-1:0]        target_tid_wb,
    input  logic                    ext_wake_vld,
    input  logic [TID_W-1:0]        ext_wake_tid,
    output logic [DATA_W-1:0]       wb_data_wb,
    output logic                    wr_en_final,
    output logic [TID_W-1:0]        wr_tid,
    output logic [REG_W-1:0]        wr_rd,
    output logic                    sleep,
    output logic                    wake,
    output logic                    kill,
    output logic [2*NUM_THREAD-1:0] trd_state,
    output logic [NUM_THREAD-1:0]   run_mask,
    output logic                    all_done
);

    logic        act;
    logic [31:0] ld_data;

    trd_state_t            state_q [NUM_THREAD];
    trd_state_t            state_d [NUM_THREAD];
    logic [NUM_THREAD-1:0] pend_q;
    logic [NUM_THREAD-1:0] pend_d;
    logic                  wake_hit;

    wb_ld_align u_align (
        .raw_i     (d_rd_data),
        .size_i    (ld_size_wb),
        .sign_i    (ld_sign_wb),
        .addr_lo_i (addr_lo_wb),
        .data_o    (ld_data)
    );

    always_comb begin
        act         = valid_wb & ~flushWB;
        wb_data_wb  = wb_sel_wb ? ld_data : exe_data_wb;
        wr_en_final = wr_en_wb & act;
        wr_tid      = tid_wb;
        wr_rd       = rd_wb;
        sleep       = 1'b0;
        wake        = 1'b0;
        kill        = 1'b0;
        case (trd_ctrl_wb)
            TRD_NONE:  ;
            TRD_SLEEP: sleep = act;
            TRD_WAKE:  wake  = act;
            TRD_KILL:  kill  = act;
            default:   ;
        endcase
    end

    // Pipeline sleep/kill resolve first; pipeline and external wakes on the
    // same thread then merge into a single wake applied to that result.
    always_comb begin
        wake_hit = 1'b0;
        for (int i = 0; i < NUM_THREAD; i++) begin
            state_d[i] = state_q[i];
            pend_d[i]  = pend_q[i];
            if (sleep && tid_wb == TID_W'(i) && state_q[i] == RUN) begin
                if (pend_q[i]) pend_d[i] = 1'b0;
                else           state_d[i] = SLEEP;
            end
            if (kill && tid_wb == TID_W'(i)) begin
                state_d[i] = FREE;
                pend_d[i]  = 1'b0;
            end
            wake_hit = (wake && target_tid_wb == TID_W'(i)) ||
                       (ext_wake_vld && ext_wake_tid == TID_W'(i));
            if (wake_hit) begin
                if (state_d[i] == RUN) pend_d[i]  = 1'b1;
                else                   state_d[i] = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_THREAD; i++) begin
                state_q[i] <= (i == 0) ? RUN : FREE;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < NUM_THREAD; i++) begin
                state_q[i] <= state_d[i];
            end
            pend_q <= pend_d;
        end
    end

    always_comb begin
        trd_state = '0;
        run_mask  = '0;
        all_done  = 1'b1;
        for (int i = 0; i < NUM_THREAD; i++) begin
            trd_state[2*i +: 2] = state_q[i];
            run_mask[i]         = (state_q[i] == RUN);
            if (state_q[i] != FREE) all_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_trd_unit.sv
// Self-checking bench for wb_trd_unit: directed scenarios plus randomized
// traffic checked against a thread-table reference model.
module tb_wb_trd_unit;

    localparam int NT = 8;
    localparam int TW = 3;

    logic          clk;
    logic          rst_n;
    logic          valid_wb;
    logic          flushWB;
    logic [TW-1:0] tid_wb;
    logic [31:0]   exe_data_wb;
    logic [31:0]   d_rd_data;
    logic          wb_sel_wb;
    logic [1:0]    ld_size_wb;
    logic          ld_sign_wb;
    logic [1:0]    addr_lo_wb;
    logic          wr_en_wb;
    logic [4:0]    rd_wb;
    logic [1:0]    trd_ctrl_wb;
    logic [TW-1:0] target_tid_wb;
    logic          ext_wake_vld;
    logic [TW-1:0] ext_wake_tid;
    logic [31:0]   wb_data_wb;
    logic          wr_en_final;
    logic [TW-1:0] wr_tid;
    logic [4:0]    wr_rd;
    logic          sleep;
    logic          wake;
    logic          kill;
    logic [2*NT-1:0] trd_state;
    logic [NT-1:0] run_mask;
    logic          all_done;

    int checks = 0;
    int errors = 0;

    // Reference table: 0 = free, 1 = run, 2 = sleep
    int model_st [NT];
    bit model_pend [NT];

    wb_trd_unit #(.NUM_THREAD(NT)) dut (
        .clk(clk), .rst_n(rst_n), .valid_wb(valid_wb), .flushWB(flushWB),
        .tid_wb(tid_wb), .exe_data_wb(exe_data_wb), .d_rd_data(d_rd_data),
        .wb_sel_wb(wb_sel_wb), .ld_size_wb(ld_size_wb), .ld_sign_wb(ld_sign_wb),
        .addr_lo_wb(addr_lo_wb), .wr_en_wb(wr_en_wb), .rd_wb(rd_wb),
        .trd_ctrl_wb(trd_ctrl_wb), .target_tid_wb(target_tid_wb),
        .ext_wake_vld(ext_wake_vld), .ext_wake_tid(ext_wake_tid),
        .wb_data_wb(wb_data_wb), .wr_en_final(wr_en_final), .wr_tid(wr_tid),
        .wr_rd(wr_rd), .sleep(sleep), .wake(wake), .kill(kill),
        .trd_state(trd_state), .run_mask(run_mask), .all_done(all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_align(logic [31:0] d, logic [1:0] sz,
                                              logic sg, logic [1:0] a);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (d >> (8 * int'(a))) & 32'h0000_00FF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (d >> (16 * int'(a[1]))) & 32'h0000_FFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic logic [2*NT-1:0] model_packed();
        logic [2*NT-1:0] p;
        p = '0;
        for (int i = 0; i < NT; i++) p[2*i +: 2] = 2'(model_st[i]);
        return p;
    endfunction

    function automatic logic [NT-1:0] model_run();
        logic [NT-1:0] m;
        m = '0;
        for (int i = 0; i < NT; i++) m[i] = (model_st[i] == 1);
        return m;
    endfunction

    function automatic logic model_done();
        for (int i = 0; i < NT; i++) if (model_st[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            model_st[i]   = (i == 0) ? 1 : 0;
            model_pend[i] = 1'b0;
        end
    endtask

    task automatic model_wake(int t);
        if (model_st[t] == 1) model_pend[t] = 1'b1;
        else                  model_st[t]   = 1;
    endtask

    // Advance the reference by one cycle from the current inputs, then clock.
    task automatic tick();
        bit act;
        bit pipe_wake_same;
        act = valid_wb && !flushWB;
        pipe_wake_same = 1'b0;
        if (act) begin
            case (trd_ctrl_wb)
                2'b01: if (model_st[tid_wb] == 1) begin
                    if (model_pend[tid_wb]) model_pend[tid_wb] = 1'b0;
                    else                    model_st[tid_wb]   = 2;
                end
                2'b10: begin
                    model_wake(int'(target_tid_wb));
                    pipe_wake_same = (target_tid_wb == ext_wake_tid);
                end
                2'b11: begin
                    model_st[tid_wb]   = 0;
                    model_pend[tid_wb] = 1'b0;
                end
                default: ;
            endcase
        end
        if (ext_wake_vld && !pipe_wake_same) model_wake(int'(ext_wake_tid));
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        valid_wb = 0; flushWB = 0; tid_wb = 0; exe_data_wb = 0; d_rd_data = 0;
        wb_sel_wb = 0; ld_size_wb = 0; ld_sign_wb = 0; addr_lo_wb = 0;
        wr_en_wb = 0; rd_wb = 0; trd_ctrl_wb = 0; target_tid_wb = 0;
        ext_wake_vld = 0; ext_wake_tid = 0;
    endtask

    task automatic issue(logic [TW-1:0] tid, logic [1:0] ctrl, logic [TW-1:0] tgt);
        valid_wb = 1; flushWB = 0; tid_wb = tid; trd_ctrl_wb = ctrl; target_tid_wb = tgt;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 0;
        model_reset();
        #12;
        checks++;
        if (trd_state !== 16'h0001) begin
            errors++; $display("[TB] FAIL reset_state: got %h want 0001", trd_state);
        end
        checks++;
        if (run_mask !== 8'h01 || all_done !== 1'b0 || wr_en_final !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: run_mask=%h all_done=%b wr_en_final=%b want 01/0/0",
                     run_mask, all_done, wr_en_final);
        end
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_align();
        logic [1:0] sz [4]  = '{2'b00, 2'b00, 2'b01, 2'b10};
        logic       sg [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0] al [4]  = '{2'b00, 2'b11, 2'b10, 2'b01};
        logic [31:0] ex [4] = '{32'hFFFF_FF85, 32'h0000_0080, 32'hFFFF_80F0, 32'h80F0_7F85};
        logic [31:0] exp_v;
        d_rd_data = 32'h80F0_7F85;
        wb_sel_wb = 1;
        for (int i = 0; i < 4; i++) begin
            ld_size_wb = sz[i]; ld_sign_wb = sg[i]; addr_lo_wb = al[i];
            #1;
            checks++;
            if (wb_data_wb !== ex[i]) begin
                errors++; $display("[TB] FAIL align_dir%0d: got %h want %h", i, wb_data_wb, ex[i]);
            end
        end
        for (int i = 0; i < 60; i++) begin
            d_rd_data = $urandom; exe_data_wb = $urandom;
            wb_sel_wb = 1'($urandom); ld_size_wb = 2'($urandom);
            ld_sign_wb = 1'($urandom); addr_lo_wb = 2'($urandom);
            #1;
            exp_v = wb_sel_wb ? ref_align(d_rd_data, ld_size_wb, ld_sign_wb, addr_lo_wb)
                              : exe_data_wb;
            checks++;
            if (wb_data_wb !== exp_v) begin
                errors++;
                $display("[TB] FAIL align_rand: sel=%b sz=%b sg=%b a=%b d=%h got %h want %h",
                         wb_sel_wb, ld_size_wb, ld_sign_wb, addr_lo_wb, d_rd_data, wb_data_wb, exp_v);
            end
        end
        drive_idle();
    endtask

    task automatic test_wake_sleep();
        issue(0, 2'b10, 3);
        #1;
        checks++;
        if (wake !== 1'b1 || sleep !== 1'b0 || kill !== 1'b0) begin
            errors++; $display("[TB] FAIL wake_pulse: wake=%b sleep=%b kill=%b want 1/0/0", wake, sleep, kill);
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if (run_mask !== 8'h09 || wake !== 1'b0) begin
            errors++; $display("[TB] FAIL wake_spawn: run_mask=%h wake=%b want 09/0", run_mask, wake);
        end
        issue(3, 2'b01, 0);
        tick();
        drive_idle();
        checks++;
        if (run_mask !== 8'h01 || trd_state !== 16'h0081) begin
            errors++; $display("[TB] FAIL sleep_tid3: run_mask=%h state=%h want 01/0081", run_mask, trd_state);
        end
    endtask

    task automatic test_wake_pending();
        issue(0, 2'b10, 3); tick();
        issue(0, 2'b10, 3); tick();
        issue(3, 2'b01, 0); tick();
        drive_idle();
        checks++;
        if (run_mask !== 8'h09) begin
            errors++; $display("[TB] FAIL pending_keeps_run: run_mask=%h want 09", run_mask);
        end
        issue(3, 2'b01, 0); tick();
        drive_idle();
        checks++;
        if (run_mask !== 8'h01 || trd_state !== 16'h0081) begin
            errors++; $display("[TB] FAIL second_sleep: run_mask=%h state=%h want 01/0081", run_mask, trd_state);
        end
    endtask

    task automatic test_flush();
        issue(0, 2'b10, 2); tick();
        issue(2, 2'b01, 0);
        flushWB = 1; wr_en_wb = 1; rd_wb = 5'd7;
        ext_wake_vld = 1; ext_wake_tid = 5;
        #1;
        checks++;
        if (wr_en_final !== 1'b0 || sleep !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_pulses: wr_en_final=%b sleep=%b want 0/0", wr_en_final, sleep);
        end
        tick();
        drive_idle();
        checks++;
        if (run_mask !== 8'h25) begin
            errors++; $display("[TB] FAIL flush_table: run_mask=%h want 25", run_mask);
        end
    endtask

    task automatic test_kill();
        issue(2, 2'b11, 0); tick();
        issue(5, 2'b11, 0); tick();
        issue(3, 2'b11, 0); tick();
        drive_idle();
        checks++;
        if (trd_state !== 16'h0001) begin
            errors++; $display("[TB] FAIL kill_others: state=%h want 0001", trd_state);
        end
        issue(0, 2'b11, 0); tick();
        drive_idle();
        checks++;
        if (run_mask !== 8'h00 || all_done !== 1'b1) begin
            errors++; $display("[TB] FAIL kill_last: run_mask=%h all_done=%b want 00/1", run_mask, all_done);
        end
        issue(1, 2'b11, 0);
        ext_wake_vld = 1; ext_wake_tid = 1;
        tick();
        drive_idle();
        checks++;
        if (run_mask !== 8'h02 || all_done !== 1'b0) begin
            errors++; $display("[TB] FAIL kill_ext_respawn: run_mask=%h all_done=%b want 02/0", run_mask, all_done);
        end
    endtask

    task automatic test_random();
        bit act;
        for (int n = 0; n < 300; n++) begin
            valid_wb = ($urandom_range(0, 9) < 8);
            flushWB = ($urandom_range(0, 4) == 0);
            tid_wb = 3'($urandom); target_tid_wb = 3'($urandom);
            trd_ctrl_wb = 2'($urandom); wr_en_wb = 1'($urandom); rd_wb = 5'($urandom);
            ext_wake_vld = ($urandom_range(0, 9) < 3); ext_wake_tid = 3'($urandom);
            #1;
            act = valid_wb && !flushWB;
            checks++;
            if (wr_en_final !== (wr_en_wb & act) || wr_tid !== tid_wb || wr_rd !== rd_wb ||
                sleep !== (act && trd_ctrl_wb == 2'b01) || wake !== (act && trd_ctrl_wb == 2'b10) ||
                kill !== (act && trd_ctrl_wb == 2'b11)) begin
                errors++;
                $display("[TB] FAIL rand_wr: we=%b tid=%0d rd=%0d s/w/k=%b%b%b act=%b ctrl=%b wr_en_wb=%b",
                         wr_en_final, wr_tid, wr_rd, sleep, wake, kill, act, trd_ctrl_wb, wr_en_wb);
            end
            tick();
            checks++;
            if (trd_state !== model_packed() || run_mask !== model_run() || all_done !== model_done()) begin
                errors++;
                $display("[TB] FAIL rand_table%0d: state=%h mask=%h done=%b want %h/%h/%b", n,
                         trd_state, run_mask, all_done, model_packed(), model_run(), model_done());
            end
        end
        drive_idle();
    endtask

    task automatic test_async_reset();
        issue(0, 2'b10, 6); tick();
        drive_idle();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (trd_state !== 16'h0001 || run_mask !== 8'h01) begin
            errors++; $display("[TB] FAIL async_reset: state=%h mask=%h want 0001/01", trd_state, run_mask);
        end
        #2;
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_load_align();
        test_wake_sleep();
        test_wake_pending();
        test_flush();
        test_kill();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
